wb_uart_fifo: RTL and testbench

Parametrised successor to the single-byte Wishbone UART peripheral. It adds TX and RX FIFOs, a runtime-programmable baud divisor, sticky error flags and a level interrupt. The block is a Wishbone B3 classic slave on the SoC peripheral bus and contains its own 8N1 serializer and deserializer.

---
 rtl/wb_uart_fifo.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_wb_uart_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_fifo.sv
// Wishbone B3 classic UART with TX/RX FIFOs, programmable baud divisor,
// sticky error flags and a registered level interrupt.

module wb_uart_fifo_buf #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wp_q, wp_d, rp_q, rp_d;
    logic        do_push, do_pop;

    assign count_o = wp_q - rp_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (count_o == '0);
    assign rdata_o = mem_q[rp_q[AW-1:0]];
    // A push on full is dropped even when a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wp_d = do_push ? wp_q + 1'b1 : wp_q;
        rp_d = do_pop  ? rp_q + 1'b1 : rp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= wdata_i;
    end
endmodule

// state     | meaning
// TX_IDLE   | line high, waiting for TX FIFO data
// TX_START  | driving start bit
// TX_DATA   | shifting 8 data bits LSB-first
// TX_STOP   | driving stop bit
// RX_IDLE   | waiting for falling edge on synchronised rx
// RX_START  | half-bit wait, then start-bit validation
// RX_DATA   | sampling 8 data bits
// RX_STOP   | sampling stop bit
// RX_WAIT   | framing error, waiting for line high
module wb_uart_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = 434,
    parameter int DIV_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic             ack_q, ack_d, irq_q, irq_d;
    logic [31:0]      dat_q, dat_d, rd_data;
    logic [DIV_W-1:0] div_q, div_d, div_in;
    logic [1:0]       irq_en_q, irq_en_d, adr;
    logic [2:0]       flags_q, flags_d;
    logic             req, wr, rd, tx_push, rx_pop, tx_busy;
    logic             tx_ovf_set, rx_ovr_set, frm_set;

    logic             tx_full, tx_empty, tx_pop;
    logic [7:0]       tx_rdata;
    logic [CW-1:0]    tx_count;
    logic             rx_full, rx_empty, rx_push;
    logic [7:0]       rx_rdata;
    logic [CW-1:0]    rx_count;

    tx_state_t        tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic             tx_q, tx_d;

    rx_state_t        rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [1:0]       rx_sync_q;
    logic             rx_prev_q, rx_s;

    logic             unused_ok;
    assign unused_ok = ^{wb_adr_i, wb_dat_i, tx_count};

    assign req      = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr       = req & wb_we_i;
    assign rd       = req & ~wb_we_i;
    assign adr      = wb_adr_i[3:2];
    assign tx_push  = wr & (adr == 2'd0);
    assign rx_pop   = rd & (adr == 2'd0);
    assign div_in   = wb_dat_i[DIV_W-1:0];
    assign tx_busy  = (tx_state_q != TX_IDLE) | ~tx_empty;
    assign tx_ovf_set = tx_push & tx_full;
    assign rx_s     = rx_sync_q[1];

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign tx       = tx_q;
    assign irq      = irq_q;

    wb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_txf (
        .clk(clk), .rst_n(rst_n), .push_i(tx_push), .pop_i(tx_pop),
        .wdata_i(wb_dat_i[7:0]), .rdata_o(tx_rdata), .full_o(tx_full),
        .empty_o(tx_empty), .count_o(tx_count)
    );

    wb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rxf (
        .clk(clk), .rst_n(rst_n), .push_i(rx_push), .pop_i(rx_pop),
        .wdata_i(rx_sh_q), .rdata_o(rx_rdata), .full_o(rx_full),
        .empty_o(rx_empty), .count_o(rx_count)
    );

    always_comb begin
        rd_data = '0;
        case (adr)
            2'd0: rd_data = rx_empty ? 32'd0 : {24'd0, rx_rdata};
            2'd1: begin
                rd_data[23:16] = 8'(rx_count);
                rd_data[7:0]   = {flags_q, tx_busy, rx_full, rx_empty, tx_empty, tx_full};
            end
            2'd2: rd_data = 32'(div_q);
            default: rd_data = {30'd0, irq_en_q};
        endcase
    end

    always_comb begin
        ack_d    = req;
        dat_d    = rd ? rd_data : dat_q;
        div_d    = div_q;
        irq_en_d = irq_en_q;
        flags_d  = flags_q;
        if (wr && adr == 2'd2) div_d = (div_in < DIV_MIN) ? DIV_MIN : div_in;
        if (wr && adr == 2'd3) irq_en_d = wb_dat_i[1:0];
        if (wr && adr == 2'd1) flags_d = flags_q & ~wb_dat_i[7:5];
        flags_d = flags_d | {tx_ovf_set, frm_set, rx_ovr_set};
        irq_d = (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & ~tx_busy)
              | ((|flags_q) & (|irq_en_q));
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        if (tx_state_q != TX_IDLE) tx_cnt_d = tx_cnt_q - ONE;
        case (tx_state_q)
            TX_START: if (tx_cnt_q == '0) begin
                tx_state_d = TX_DATA;
                tx_cnt_d   = tx_div_q - ONE;
                tx_d       = tx_sh_q[0];
                tx_bit_d   = 3'd0;
            end
            TX_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = tx_div_q - ONE;
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = TX_STOP;
                    tx_d       = 1'b1;
                end else begin
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_d     = tx_sh_q[1];
                    tx_bit_d = tx_bit_q + 3'd1;
                end
            end
            TX_STOP: if (tx_cnt_q == '0) tx_state_d = TX_IDLE;
            default: ;
        endcase
        // Loading at the last stop cycle makes back-to-back frames gapless.
        if ((tx_state_q == TX_IDLE || (tx_state_q == TX_STOP && tx_cnt_q == '0)) && !tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_rdata;
            tx_div_d   = div_q;
            tx_cnt_d   = div_q - ONE;
            tx_d       = 1'b0;
            tx_state_d = TX_START;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_sh_d    = rx_sh_q;
        rx_bit_d   = rx_bit_q;
        rx_push    = 1'b0;
        rx_ovr_set = 1'b0;
        frm_set    = 1'b0;
        if (rx_state_q != RX_IDLE && rx_state_q != RX_WAIT) rx_cnt_d = rx_cnt_q - ONE;
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_s) begin
                rx_div_d   = div_q;
                rx_cnt_d   = (div_q >> 1) - ONE;
                rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == '0) begin
                if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d   = rx_div_q - ONE;
                    rx_bit_d   = 3'd0;
                    rx_state_d = RX_DATA;
                end
            end
            RX_DATA: if (rx_cnt_q == '0) begin
                rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                rx_cnt_d = rx_div_q - ONE;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                else                  rx_bit_d   = rx_bit_q + 3'd1;
            end
            RX_STOP: if (rx_cnt_q == '0) begin
                if (rx_s) begin
                    rx_push    = 1'b1;
                    rx_ovr_set = rx_full;
                    rx_state_d = RX_IDLE;
                end else begin
                    frm_set    = 1'b1;
                    rx_state_d = RX_WAIT;
                end
            end
            RX_WAIT: if (rx_s) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            irq_q      <= 1'b0;
            div_q      <= DIV_W'(DIV_RESET);
            irq_en_q   <= '0;
            flags_q    <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_sh_q    <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_sh_q    <= '0;
            rx_bit_q   <= '0;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
            div_q      <= div_d;
            irq_en_q   <= irq_en_d;
            flags_q    <= flags_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_sh_q    <= rx_sh_d;
            rx_bit_q   <= rx_bit_d;
            rx_sync_q  <= {rx_sync_q[0], rx};
            rx_prev_q  <= rx_s;
        end
    end
endmodule

// File: tb/tb_wb_uart_fifo.sv
// Scoreboard bench for wb_uart_fifo: bus reads are queued with expected data
// and checked by an ack monitor; serial timing is checked cycle by cycle.

module tb_wb_uart_fifo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
    logic        tx, rx, irq;
    logic        loop_en, rx_drv;

    typedef struct {
        bit          rd;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  n_chk = 0;
    int  n_fail = 0;

    assign rx = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    wb_uart_fifo #(.FIFO_DEPTH(4), .DIV_RESET(434), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
        .wb_ack_o(wb_ack_o), .tx(tx), .rx(rx), .irq(irq)
    );

    always @(negedge clk) begin
        if (rst_n && wb_ack_o) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: ack with no access pending");
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.rd) begin
                    n_chk++;
                    if (wb_dat_o !== mon_e.exp) begin
                        n_fail++;
                        $display("FAIL read_data: got 0x%08h expected 0x%08h", wb_dat_o, mon_e.exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic acc(input logic we, input logic [3:0] a, input logic [31:0] d, input logic [31:0] e);
        int  n;
        sb_t s;
        s.rd = !we;
        s.exp = e;
        sb_q.push_back(s);
        wb_adr_i = {28'd0, a};
        wb_dat_i = d;
        wb_we_i  = we;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_ack_o && n < 8);
        if (!wb_ack_o) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: no ack for adr 0x%0h", a);
            void'(sb_q.pop_back());
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (8) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_rx_push(output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < 400 && !ok) begin
            @(negedge clk);
            n++;
            if (dut.rx_empty == 1'b0) ok = 1'b1;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL rx_push_timeout: rx_empty still 1 after %0d cycles", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] fr;
        int         n, b;
        bit         ok;

        rst_n = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and register readback, including the divisor floor
        chk("reset_tx", tx, 1);
        chk("reset_irq", irq, 0);
        chk("reset_ack", wb_ack_o, 0);
        chk("reset_dat", wb_dat_o, 0);
        acc(0, 4'h4, 0, 32'h0000_0006);
        acc(0, 4'h8, 0, 32'd434);
        acc(0, 4'hC, 0, 32'd0);
        acc(1, 4'h8, 32'd2, 0);
        acc(0, 4'h8, 0, 32'd4);
        acc(1, 4'h8, 32'd8, 0);
        acc(0, 4'h8, 0, 32'd8);

        // Single frame 0xA5: exact bit timing and busy fall
        fr = {1'b1, 8'hA5, 1'b0};
        acc(1, 4'h0, 32'hA5, 0);
        @(negedge clk);
        chk("tx_before_pop", tx, 1);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            chk("tx_bit", tx, fr[k/8]);
            if (k == 79) chk("busy_last_stop", dut.tx_busy, 1);
        end
        @(negedge clk);
        chk("busy_after_stop", dut.tx_busy, 0);
        chk("tx_idle", tx, 1);
        acc(0, 4'h4, 0, 32'h0000_0006);

        // Loopback of four back-to-back frames
        loop_en = 1'b1;
        fork
            begin
                acc(1, 4'h0, 32'h00, 0);
                acc(1, 4'h0, 32'h55, 0);
                acc(1, 4'h0, 32'hFF, 0);
                acc(1, 4'h0, 32'h3C, 0);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (tx !== 1'b0 && n < 50);
                b = 0;
                while (dut.tx_busy && b < 1000) begin
                    b++;
                    @(negedge clk);
                end
                chk("abut_busy_len", b, 320);
            end
        join
        repeat (20) @(negedge clk);
        acc(0, 4'h4, 0, 32'h0004_000A);
        acc(0, 4'h0, 0, 32'h00);
        acc(0, 4'h0, 0, 32'h55);
        acc(0, 4'h0, 0, 32'hFF);
        acc(0, 4'h0, 0, 32'h3C);
        acc(0, 4'h0, 0, 32'h00);
        acc(0, 4'h4, 0, 32'h0000_0006);

        // Overflow on both FIFOs (depth 4): sixth TX byte dropped, fifth RX byte dropped
        acc(1, 4'h0, 32'h11, 0);
        acc(1, 4'h0, 32'h22, 0);
        acc(1, 4'h0, 32'h33, 0);
        acc(1, 4'h0, 32'h44, 0);
        acc(1, 4'h0, 32'h55, 0);
        acc(1, 4'h0, 32'h66, 0);
        repeat (480) @(negedge clk);
        acc(0, 4'h4, 0, 32'h0004_00AA);
        acc(1, 4'h4, 32'h20, 0);
        acc(0, 4'h4, 0, 32'h0004_008A);
        acc(1, 4'h4, 32'h80, 0);
        acc(0, 4'h4, 0, 32'h0004_000A);
        acc(0, 4'h0, 0, 32'h11);
        acc(0, 4'h0, 0, 32'h22);
        acc(0, 4'h0, 0, 32'h33);
        acc(0, 4'h0, 0, 32'h44);
        acc(0, 4'h4, 0, 32'h0000_0006);

        // Framing error and start-bit glitch
        loop_en = 1'b0;
        @(negedge clk);
        send_rx(8'h41, 1'b0);
        repeat (8) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        acc(0, 4'h4, 0, 32'h0000_0046);
        acc(1, 4'h4, 32'h40, 0);
        acc(0, 4'h4, 0, 32'h0000_0006);
        @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        acc(0, 4'h4, 0, 32'h0000_0006);

        // Interrupt timing and held strobe
        acc(1, 4'hC, 32'h1, 0);
        acc(0, 4'hC, 0, 32'h1);
        loop_en = 1'b1;
        acc(1, 4'h0, 32'h5A, 0);
        wait_rx_push(ok);
        if (ok) begin
            chk("irq_at_push", irq, 0);
            @(negedge clk);
            chk("irq_after_push", irq, 1);
        end
        acc(0, 4'h0, 0, 32'h5A);
        @(negedge clk);
        chk("irq_pop_cycle", irq, 1);
        @(negedge clk);
        chk("irq_after_pop", irq, 0);
        acc(1, 4'h0, 32'hC3, 0);
        acc(1, 4'h0, 32'h7E, 0);
        repeat (220) @(negedge clk);
        sb_q.push_back('{rd: 1'b1, exp: 32'hC3});
        sb_q.push_back('{rd: 1'b1, exp: 32'h7E});
        wb_adr_i = 32'h0; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(negedge clk);
        chk("hold_ack1", wb_ack_o, 1);
        @(negedge clk);
        chk("hold_ack2", wb_ack_o, 0);
        @(posedge clk);
        #1;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        @(negedge clk);
        chk("hold_ack3", wb_ack_o, 1);
        @(negedge clk);
        chk("hold_ack4", wb_ack_o, 0);
        acc(0, 4'h4, 0, 32'h0000_0006);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
